// File: rtl/cnn_pkg.sv
// cnn_pkg: loader FSM states and ternary weight type shared by the CNN weight path
package cnn_pkg;
  typedef enum logic [2:0] {L_IDLE, L_COLLECT, L_WRITE, L_START, L_DONE} loader_state_t;
  typedef logic signed [1:0] weight_t;
endpackage

// File: rtl/cnn_weight_loader.sv
// cnn_weight_loader: assembles serial ternary weights into kernels, writes them to feature memory, then fires the CNN start pulse
module cnn_weight_loader
  import cnn_pkg::*;
#(
  parameter int KERNEL_SIZE  = 3,
  parameter int NUM_FEATURES = 2,
  parameter int WRITE_CYCLES = 2,
  parameter int ADDR_W       = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst_cnn,
  input  logic                                 load_start,
  input  logic [1:0]                           weight_in,
  input  logic                                 weight_valid,
  output logic                                 weight_ready,
  output logic [2*KERNEL_SIZE*KERNEL_SIZE-1:0] weights_output,
  output logic [ADDR_W-1:0]                    feature_writeAddr,
  output logic                                 feature_WrEn,
  output logic                                 convolution_enable,
  output logic                                 load_done,
  output logic                                 weight_err
);
  localparam int KK = KERNEL_SIZE * KERNEL_SIZE;
  localparam int EW = (KK > 1) ? $clog2(KK) : 1;
  localparam int WW = $clog2(WRITE_CYCLES + 1);
  localparam logic [EW-1:0] ELEM_LAST = EW'(KK - 1);
  localparam logic [WW-1:0] WR_LAST = WW'(WRITE_CYCLES);
  localparam logic [ADDR_W-1:0] FEAT_LAST = ADDR_W'(NUM_FEATURES - 1);
  loader_state_t state;
  weight_t kern [KK];
  logic [2*KK-1:0] kern_flat;
  logic [EW-1:0] elem_cnt;
  logic [WW-1:0] wr_cnt;
  logic [ADDR_W-1:0] feat_cnt;
  logic illegal;
  assign illegal = weight_in == 2'b10;
  always_comb begin
    kern_flat = '0;
    for (int i = 0; i < KK; i++) kern_flat[2*i+:2] = kern[i];
  end
  always_ff @(posedge clk or negedge rst_cnn) begin
    if (!rst_cnn) begin
      state <= L_IDLE;
      weight_ready <= 1'b0;
      weights_output <= '0;
      feature_writeAddr <= '0;
      feature_WrEn <= 1'b1;
      convolution_enable <= 1'b1;
      load_done <= 1'b0;
      weight_err <= 1'b0;
      elem_cnt <= '0;
      feat_cnt <= '0;
      wr_cnt <= '0;
      kern <= '{default: '0};
    end else begin
      case (state)
        L_IDLE, L_DONE: if (load_start) begin
          state <= L_COLLECT;
          weight_ready <= 1'b1;
          feat_cnt <= '0;
          elem_cnt <= '0;
          weight_err <= 1'b0;
          load_done <= 1'b0;
        end
        L_COLLECT: if (weight_valid && weight_ready) begin
          // -2 is not a ternary value; clamp it to -1 and flag the sequence
          kern[elem_cnt] <= illegal ? 2'b11 : weight_in;
          if (illegal) weight_err <= 1'b1;
          if (elem_cnt == ELEM_LAST) begin
            state <= L_WRITE;
            weight_ready <= 1'b0;
            elem_cnt <= '0;
            wr_cnt <= '0;
          end else elem_cnt <= elem_cnt + 1'b1;
        end
        L_WRITE: begin
          // wr_cnt==0 is the setup cycle that presents data and address with WrEn
          if (wr_cnt == '0) begin
            weights_output <= kern_flat;
            feature_writeAddr <= feat_cnt;
            feature_WrEn <= 1'b0;
            wr_cnt <= 1'b1;
          end else if (wr_cnt == WR_LAST) begin
            feature_WrEn <= 1'b1;
            feat_cnt <= feat_cnt + 1'b1;
            state <= (feat_cnt == FEAT_LAST) ? L_START : L_COLLECT;
            weight_ready <= feat_cnt != FEAT_LAST;
            convolution_enable <= feat_cnt != FEAT_LAST;
          end else wr_cnt <= wr_cnt + 1'b1;
        end
        L_START: begin
          convolution_enable <= 1'b1;
          load_done <= 1'b1;
          state <= L_DONE;
        end
        default: state <= L_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cnn_weight_loader.sv
// tb_cnn_weight_loader: directed stimulus with a scoreboard queue checked by an output monitor
module tb_cnn_weight_loader;
  localparam int KK = 9;
  localparam logic [17:0] KX = 18'h1DDDD;
  localparam logic [17:0] K1 = 18'h15555;
  localparam logic [17:0] K3S = 18'h30201;
  localparam logic [17:0] K3E = 18'h30301;
  typedef struct {
    bit is_start;
    logic [0:0] addr;
    logic [17:0] kern;
  } exp_t;
  logic clk = 0, rst_cnn, load_start, weight_valid, weight_ready;
  logic [1:0] weight_in;
  logic [17:0] weights_output;
  logic [0:0] feature_writeAddr;
  logic feature_WrEn, convolution_enable, load_done, weight_err;
  exp_t exp_q[$];
  exp_t cur;
  int errors = 0, checks = 0, win_len = 0;
  bit prev_wren = 1, prev_cen = 1, in_win = 0, ok;
  always #5 clk = ~clk;
  cnn_weight_loader dut (
    .clk(clk), .rst_cnn(rst_cnn), .load_start(load_start), .weight_in(weight_in),
    .weight_valid(weight_valid), .weight_ready(weight_ready), .weights_output(weights_output),
    .feature_writeAddr(feature_writeAddr), .feature_WrEn(feature_WrEn),
    .convolution_enable(convolution_enable), .load_done(load_done), .weight_err(weight_err)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic expect_write(input logic [0:0] a, input logic [17:0] k);
    exp_t e;
    e.is_start = 0; e.addr = a; e.kern = k;
    exp_q.push_back(e);
  endtask
  task automatic expect_start();
    exp_t e;
    e.is_start = 1; e.addr = '0; e.kern = '0;
    exp_q.push_back(e);
  endtask
  task automatic pulse_start();
    @(negedge clk) load_start = 1;
    @(negedge clk) load_start = 0;
  endtask
  task automatic send(input logic [17:0] k, input bit gaps, input int lo, input int hi);
    int i = lo, t = 0;
    bit skip = 0;
    while (i < hi && t < 200) begin
      @(negedge clk); t++;
      if (gaps && skip) begin weight_valid = 0; weight_in = 2'b00; skip = 0; end
      else if (weight_ready) begin weight_valid = 1; weight_in = k[2*i+:2]; i++; skip = 1; end
      else begin weight_valid = gaps; weight_in = 2'b10; end
    end
    @(negedge clk) weight_valid = 0;
    chk("weights_sent", i, hi);
  endtask
  task automatic wait_done();
    int t = 0;
    while (!load_done && t < 100) begin @(negedge clk); t++; end
    chk("load_done", load_done, 1);
  endtask
  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 50) begin @(negedge clk); t++; end
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask
  task automatic chk_reset();
    chk("rst_weight_ready", weight_ready, 0);
    chk("rst_weights_output", weights_output, 0);
    chk("rst_addr", feature_writeAddr, 0);
    chk("rst_wren", feature_WrEn, 1);
    chk("rst_conv_en", convolution_enable, 1);
    chk("rst_load_done", load_done, 0);
    chk("rst_weight_err", weight_err, 0);
  endtask
  always @(negedge clk) begin
    if (!rst_cnn) begin
      prev_wren = 1; prev_cen = 1; in_win = 0; win_len = 0;
    end else begin
      if (!feature_WrEn) begin
        if (prev_wren) begin
          in_win = exp_q.size() > 0 && !exp_q[0].is_start;
          chk("write_expected", in_win, 1);
          if (in_win) cur = exp_q.pop_front();
          win_len = 0;
        end
        win_len++;
        if (in_win) begin
          chk("weights_output", weights_output, cur.kern);
          chk("feature_writeAddr", feature_writeAddr, cur.addr);
        end
      end else if (!prev_wren) chk("wren_low_cycles", win_len, 2);
      if (!convolution_enable && prev_cen) begin
        ok = exp_q.size() > 0 && exp_q[0].is_start;
        chk("start_expected", ok, 1);
        if (ok) void'(exp_q.pop_front());
      end
      if (!prev_cen) begin
        chk("conv_en_one_cycle", convolution_enable, 1);
        chk("load_done_after_start", load_done, 1);
      end
      prev_wren = feature_WrEn;
      prev_cen = convolution_enable;
    end
  end
  initial begin
    rst_cnn = 0; load_start = 0; weight_in = 0; weight_valid = 0;
    repeat (3) @(negedge clk);
    chk_reset();
    rst_cnn = 1;
    // 1: X kernel then all-ones, valid held high
    pulse_start();
    expect_write(0, KX); expect_write(1, K1); expect_start();
    send(KX, 0, 0, KK);
    send(K1, 0, 0, KK);
    wait_done();
    chk("no_err_t1", weight_err, 0);
    drain();
    // 2: same stream with gaps and junk offered while not ready
    pulse_start();
    chk("load_done_cleared", load_done, 0);
    expect_write(0, KX); expect_write(1, K1); expect_start();
    send(KX, 1, 0, KK);
    send(K1, 1, 0, KK);
    wait_done();
    chk("no_err_t2", weight_err, 0);
    drain();
    // 3: illegal -2 at element 4
    pulse_start();
    expect_write(0, K3E); expect_write(1, K1); expect_start();
    send(K3S, 0, 0, KK);
    chk("weight_err_set", weight_err, 1);
    send(K1, 0, 0, KK);
    wait_done();
    chk("weight_err_sticky", weight_err, 1);
    drain();
    pulse_start();
    chk("weight_err_cleared", weight_err, 0);
    // 4: reset after 5 weights discards the partial kernel
    send(KX, 0, 0, 5);
    @(negedge clk) rst_cnn = 0;
    #1 chk_reset();
    @(negedge clk) rst_cnn = 1;
    repeat (5) @(negedge clk);
    pulse_start();
    expect_write(0, KX); expect_write(1, K1); expect_start();
    send(KX, 0, 0, KK);
    send(K1, 0, 0, KK);
    wait_done();
    drain();
    // 5: load_start ignored in COLLECT and WRITE, honoured in DONE
    pulse_start();
    expect_write(0, K1); expect_write(1, KX); expect_start();
    send(K1, 0, 0, 4);
    pulse_start();
    send(K1, 0, 4, KK);
    chk("ready_low_in_write", weight_ready, 0);
    pulse_start();
    send(KX, 0, 0, KK);
    wait_done();
    drain();
    pulse_start();
    chk("reload_done_cleared", load_done, 0);
    expect_write(0, KX); expect_write(1, K3E); expect_start();
    send(KX, 1, 0, KK);
    send(K3S, 0, 0, KK);
    wait_done();
    chk("reload_err", weight_err, 1);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
